// File: rtl/hist_cdf.sv
// hist_cdf: per-frame 256-bin histogram of the V channel with CDF readout.
// Pixels increment bins through a two-stage read-modify-write pipeline.
// At frame end the bins are streamed out as a running (saturating) sum,
// and each bin is zeroed as it is read, so the next frame starts clean.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_CLEAR | zero bins 0..255 after reset, one per cycle, then one idle
// ST_ACC   | accept pixels, increment bins; src_last ends the frame
// ST_FLUSH | two cycles for the last increments to reach the RAM
// ST_READ  | read bins 0..255 with clear-on-read, emit CDF, one idle
module hist_cdf #(
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             src_valid,
  input  logic [7:0]       src_data,
  input  logic             src_last,
  output logic             src_ready,
  output logic             dst_valid,
  output logic [7:0]       dst_addr,
  output logic [CNT_W-1:0] dst_data,
  output logic             dst_last
);

  localparam logic [1:0] ST_CLEAR = 2'd0;
  localparam logic [1:0] ST_ACC   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_READ  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]       state_q, state_d;
  logic [8:0]       cnt_q, cnt_d;
  logic             src_ready_q, src_ready_d;
  logic             accept;

  logic [CNT_W-1:0] mem_q [256];
  logic [CNT_W-1:0] rd_q;
  logic [7:0]       raddr;
  logic             we;
  logic [7:0]       waddr;
  logic [CNT_W-1:0] wdata;

  logic             s1_valid_q;
  logic [7:0]       s1_addr_q;
  logic             s2_valid_q;
  logic [7:0]       s2_addr_q;
  logic [CNT_W-1:0] s2_data_q;
  logic [CNT_W-1:0] base;
  logic [CNT_W-1:0] inc;

  logic             rv_q;
  logic [7:0]       ra_q;
  logic             reading;
  logic [CNT_W-1:0] sum_prev;
  logic [CNT_W:0]   sum_wide;
  logic [CNT_W-1:0] sum_sat;

  logic             dst_valid_q;
  logic [7:0]       dst_addr_q;
  logic [CNT_W-1:0] dst_data_q;
  logic             dst_last_q;

  // src_ready is only ever high in ST_ACC, so it alone qualifies a beat
  assign accept  = src_valid & src_ready_q;
  assign reading = (state_q == ST_READ) && !cnt_q[8];

  // Sequencing: CLEAR and READ each use cnt_q 0..255 for bins, 256 as a
  // one-cycle tail so src_ready rises one cycle after the last write/beat.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    src_ready_d = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + 9'd1;
        if (cnt_q == 9'd256) begin
          state_d = ST_ACC;
          cnt_d   = 9'd0;
        end
      end
      ST_ACC: begin
        src_ready_d = 1'b1;
        if (accept && src_last) begin
          state_d     = ST_FLUSH;
          src_ready_d = 1'b0;
          cnt_d       = 9'd0;
        end
      end
      ST_FLUSH: begin
        cnt_d = cnt_q + 9'd1;
        if (cnt_q == 9'd1) begin
          state_d = ST_READ;
          cnt_d   = 9'd0;
        end
      end
      ST_READ: begin
        cnt_d = cnt_q + 9'd1;
        if (cnt_q == 9'd256) begin
          state_d = ST_ACC;
          cnt_d   = 9'd0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = 9'd0;
      end
    endcase
  end

  // State, counter and ready register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_CLEAR;
      cnt_q       <= 9'd0;
      src_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      src_ready_q <= src_ready_d;
    end
  end

  // Increment stage. A beat one cycle behind the same bin reads the RAM in
  // the same edge the older write lands, so it takes the value from stage 2.
  // Distance-2 repeats read after that write has landed and need no bypass.
  always_comb begin
    base = rd_q;
    if (s2_valid_q && (s2_addr_q == s1_addr_q)) base = s2_data_q;
    inc = (base == CNT_MAX) ? CNT_MAX : base + CNT_W'(1);
  end

  // Single RAM write port: pixel increments, else clear sweep (CLEAR/READ)
  always_comb begin
    we    = 1'b0;
    waddr = s1_addr_q;
    wdata = inc;
    if (s1_valid_q) begin
      we = 1'b1;
    end else if (((state_q == ST_CLEAR) || (state_q == ST_READ)) && !cnt_q[8]) begin
      we    = 1'b1;
      waddr = cnt_q[7:0];
      wdata = '0;
    end
  end

  assign raddr = (state_q == ST_READ) ? cnt_q[7:0] : src_data;

  // Bin RAM, read-first, registered read
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    rd_q <= mem_q[raddr];
  end

  // Pipeline tags for the increment path and the readout path
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_addr_q  <= 8'd0;
      s2_valid_q <= 1'b0;
      s2_addr_q  <= 8'd0;
      s2_data_q  <= '0;
      rv_q       <= 1'b0;
      ra_q       <= 8'd0;
    end else begin
      s1_valid_q <= accept;
      s1_addr_q  <= src_data;
      s2_valid_q <= s1_valid_q;
      s2_addr_q  <= s1_addr_q;
      s2_data_q  <= inc;
      rv_q       <= reading;
      ra_q       <= cnt_q[7:0];
    end
  end

  // Running sum restarts at bin 0; dst_data_q doubles as the accumulator
  always_comb begin
    sum_prev = (ra_q == 8'd0) ? '0 : dst_data_q;
    sum_wide = {1'b0, sum_prev} + {1'b0, rd_q};
    sum_sat  = sum_wide[CNT_W] ? CNT_MAX : sum_wide[CNT_W-1:0];
  end

  // Registered CDF output stream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dst_valid_q <= 1'b0;
      dst_addr_q  <= 8'd0;
      dst_data_q  <= '0;
      dst_last_q  <= 1'b0;
    end else if (rv_q) begin
      dst_valid_q <= 1'b1;
      dst_addr_q  <= ra_q;
      dst_data_q  <= sum_sat;
      dst_last_q  <= (ra_q == 8'hFF);
    end else begin
      dst_valid_q <= 1'b0;
      dst_last_q  <= 1'b0;
    end
  end

  assign src_ready = src_ready_q;
  assign dst_valid = dst_valid_q;
  assign dst_addr  = dst_addr_q;
  assign dst_data  = dst_data_q;
  assign dst_last  = dst_last_q;

endmodule

// File: tb/tb_hist_cdf.sv
// Testbench for hist_cdf: a 20-bit and a 4-bit instance share one stimulus
// stream; expected CDFs are pushed per frame and checked by a monitor.
module tb_hist_cdf;

  typedef struct {
    logic [7:0]  addr;
    logic [19:0] data;
    logic        last;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        src_valid;
  logic [7:0]  src_data;
  logic        src_last;

  logic        src_ready;
  logic        dst_valid;
  logic [7:0]  dst_addr;
  logic [19:0] dst_data;
  logic        dst_last;

  logic        src_ready_n;
  logic        dst_valid_n;
  logic [7:0]  dst_addr_n;
  logic [3:0]  dst_data_n;
  logic        dst_last_n;

  int checks = 0;
  int errors = 0;

  exp_t q_w[$];
  exp_t q_n[$];
  int   pix_q[$];

  hist_cdf #(.CNT_W(20)) dut (
    .clk(clk), .rst_n(rst_n),
    .src_valid(src_valid), .src_data(src_data), .src_last(src_last),
    .src_ready(src_ready),
    .dst_valid(dst_valid), .dst_addr(dst_addr), .dst_data(dst_data), .dst_last(dst_last)
  );

  hist_cdf #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .src_valid(src_valid), .src_data(src_data), .src_last(src_last),
    .src_ready(src_ready_n),
    .dst_valid(dst_valid_n), .dst_addr(dst_addr_n), .dst_data(dst_data_n), .dst_last(dst_last_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // Hand-derived CDF (without saturation) for each directed frame
  function automatic int exp_cdf(input int fid, input int k);
    case (fid)
      1: return k + 1;
      2: return (k < 7) ? 0 : 1000;
      3: begin
        if (k < 3) return 0;
        else if (k < 5) return 3;
        else if (k < 9) return 5;
        else return 6;
      end
      4: return (k < 200) ? 0 : 10;
      5: return 4;
      6: return 20;
      7: begin
        if (k < 1) return 0;
        else if (k < 2) return 10;
        else return 20;
      end
      default: return 0;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic load_frame(input int fid);
    pix_q.delete();
    case (fid)
      1: for (int i = 0; i < 256; i++) pix_q.push_back(i);
      2: for (int i = 0; i < 1000; i++) pix_q.push_back(7);
      3: begin
        pix_q.push_back(3); pix_q.push_back(5); pix_q.push_back(3);
        pix_q.push_back(5); pix_q.push_back(3); pix_q.push_back(9);
      end
      4: for (int i = 0; i < 10; i++) pix_q.push_back(200);
      5: for (int i = 0; i < 4; i++) pix_q.push_back(0);
      6: for (int i = 0; i < 20; i++) pix_q.push_back(0);
      7: begin
        for (int i = 0; i < 10; i++) pix_q.push_back(1);
        for (int i = 0; i < 10; i++) pix_q.push_back(2);
      end
      default: pix_q.push_back(0);
    endcase
  endtask

  task automatic push_expected(input int fid);
    exp_t e;
    int   v;
    for (int k = 0; k < 256; k++) begin
      v      = exp_cdf(fid, k);
      e.addr = 8'(k);
      e.last = (k == 255);
      e.data = 20'(v);
      q_w.push_back(e);
      e.data = (v > 15) ? 20'd15 : 20'(v);
      q_n.push_back(e);
    end
  endtask

  // Drives pix_q; returns at #1 after the edge that sampled the last beat
  task automatic send_frame(input string name);
    int  i;
    int  guard;
    int  n;
    logic acc;
    i = 0;
    guard = 0;
    n = pix_q.size();
    while ((i < n) && (guard < n + 600)) begin
      src_valid = 1'b1;
      src_data  = 8'(pix_q[i]);
      src_last  = (i == n - 1);
      acc = src_ready;
      @(posedge clk);
      #1;
      guard++;
      if (acc) i++;
    end
    src_valid = 1'b0;
    src_last  = 1'b0;
    if (i != n) check({name, "_send_timeout"}, i, n);
  endtask

  // Readout timing relative to edge T (the edge that took src_last)
  task automatic check_readout(input string name);
    int bad;
    check({name, "_ready_low_at_T"}, int'(src_ready), 0);
    repeat (3) @(posedge clk);
    #1;
    check({name, "_no_valid_T3"}, int'(dst_valid), 0);
    @(posedge clk);
    #1;
    check({name, "_bin0_valid_T4"}, int'(dst_valid), 1);
    check({name, "_bin0_addr"}, int'(dst_addr), 0);
    bad = 0;
    if (dst_last) bad++;
    for (int k = 1; k < 256; k++) begin
      @(posedge clk);
      #1;
      if (!dst_valid || (int'(dst_addr) != k) || src_ready || (dst_last != (k == 255))) bad++;
    end
    check({name, "_readout_stream"}, bad, 0);
    @(posedge clk);
    #1;
    check({name, "_ready_after_last"}, int'(src_ready), 1);
    check({name, "_valid_dropped"}, int'(dst_valid), 0);
  endtask

  task automatic wait_ready_after_reset(input string name);
    int c;
    c = 0;
    for (int i = 1; i <= 400; i++) begin
      @(posedge clk);
      #1;
      if (src_ready) begin
        c = i;
        break;
      end
    end
    check({name, "_ready_rise_cycle"}, c, 258);
  endtask

  task automatic run_frame(input int fid, input string name);
    load_frame(fid);
    push_expected(fid);
    send_frame(name);
    check_readout(name);
  endtask

  // Monitor: compare every presented CDF beat against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (dst_valid) begin
      checks++;
      if (q_w.size() == 0) begin
        errors++;
        $display("FAIL cdf20_unexpected: got addr %0d data %0d, expected no beat", dst_addr, dst_data);
      end else begin
        e = q_w.pop_front();
        if ((dst_addr !== e.addr) || (dst_data !== e.data) || (dst_last !== e.last)) begin
          errors++;
          $display("FAIL cdf20: got addr %0d data %0d last %0b, expected addr %0d data %0d last %0b",
                   dst_addr, dst_data, dst_last, e.addr, e.data, e.last);
        end
      end
    end
    if (dst_valid_n) begin
      checks++;
      if (q_n.size() == 0) begin
        errors++;
        $display("FAIL cdf4_unexpected: got addr %0d data %0d, expected no beat", dst_addr_n, dst_data_n);
      end else begin
        e = q_n.pop_front();
        if ((dst_addr_n !== e.addr) || ({16'd0, dst_data_n} !== e.data) || (dst_last_n !== e.last)) begin
          errors++;
          $display("FAIL cdf4: got addr %0d data %0d last %0b, expected addr %0d data %0d last %0b",
                   dst_addr_n, dst_data_n, dst_last_n, e.addr, e.data, e.last);
        end
      end
    end
  end

  initial begin
    int seen;
    rst_n     = 1'b0;
    src_valid = 1'b0;
    src_data  = 8'd0;
    src_last  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_src_ready", int'(src_ready), 0);
    check("rst_dst_valid", int'(dst_valid), 0);
    check("rst_dst_addr", int'(dst_addr), 0);
    check("rst_dst_data", int'(dst_data), 0);
    check("rst_dst_last", int'(dst_last), 0);
    rst_n = 1'b1;
    wait_ready_after_reset("init");

    run_frame(1, "ramp");
    run_frame(2, "same7");
    run_frame(3, "dist2");

    // Frame A, then src_valid held high through READ, then frame B at once
    load_frame(4);
    push_expected(4);
    send_frame("frameA");
    src_valid = 1'b1;
    src_data  = 8'd0;
    src_last  = 1'b0;
    check_readout("frameA");
    run_frame(5, "frameB");

    run_frame(6, "sat20x0");
    run_frame(7, "sat1_2");

    // Abort a readout at bin 100 with reset
    load_frame(1);
    push_expected(1);
    send_frame("abort");
    seen = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (dst_valid && (dst_addr == 8'd100)) begin
        seen = 1;
        break;
      end
    end
    check("abort_reached_bin100", seen, 1);
    rst_n = 1'b0;
    #1;
    check("abort_src_ready", int'(src_ready), 0);
    check("abort_dst_valid", int'(dst_valid), 0);
    check("abort_dst_addr", int'(dst_addr), 0);
    check("abort_dst_data", int'(dst_data), 0);
    check("abort_dst_last", int'(dst_last), 0);
    q_w.delete();
    q_n.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_ready_after_reset("abort");
    run_frame(3, "after_abort");

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard20_drained", q_w.size(), 0);
    check("scoreboard4_drained", q_n.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
